dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Memory-side responder for the core's data bus: accepts one load/store request at a time over a valid/ready handshake. It services the request from an internal word array after a fixed, parameterised latency. It returns read data plus an error flag. It is the slave counterpart to the core's data-memory port, used for multi-cycle memory integration and as the reference memory in core benches.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words stored (power of two, >=2)
LATENCY, 2, cycles from request accept edge to resp_valid assertion (>=1)
BASE_ADDR, 32'h0, byte address of word 0 (word aligned)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_addr  input  32  byte address
req_we  input  1  1 = store, 0 = load
req_wdata  input  32  store data
req_strb  input  4  byte enables for store; bit i covers bits [8i+7:8i]
resp_valid  output  1  response present
resp_ready  input  1  requester consumes response
resp_rdata  output  32  load data; 0 for stores and errors
resp_err  output  1  misaligned or out-of-range access

Behaviour:
- FSM states: IDLE, BUSY, RESP. A down-counter of width clog2(LATENCY+1) is used.
- req_ready = (state==IDLE) and reset deasserted. It is combinational from state only.
- Accept occurs at a rising edge with req_valid && req_ready.
  - Latch addr, we, wdata, strb.
  - Load counter = LATENCY-1.
  - Go to BUSY.
- BUSY:
  - Counter decrements each edge.
  - At the edge where counter==0, perform the access and go to RESP.
  - resp_valid therefore first reads 1 exactly LATENCY cycles after the accept edge.
- Access decode:
  - offset = addr - BASE_ADDR, computed 32-bit unsigned with wrap.
  - err = (addr[1:0]!=0) || (offset >= 4*DEPTH_WORDS).
  - index = offset[clog2(DEPTH_WORDS)+1:2].
- Access result:
  - Load, no err: resp_rdata = mem[index].
  - Store, no err: mem[index] bytes with strb=1 updated, others kept; resp_rdata=0.
  - Any err: no memory update, resp_rdata=0, resp_err=1.
  - Store with strb=4'b0000: no change, err=0 (legal no-op).
- RESP:
  - resp_valid=1; resp_rdata and resp_err are registered and held stable until the handshake.
  - On resp_valid && resp_ready, go to IDLE. req_ready=1 in the following cycle.
  - No same-cycle response-accept/request-accept overlap. Minimum occupancy per transaction is LATENCY+2 cycles.
- Request inputs are ignored whenever req_ready=0. Changes on them while BUSY/RESP do not affect the latched transaction.
- resp_ready while not in RESP is ignored.
- Reset (reset=0, any time, asynchronous):
  - State IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0.
  - A pending store in BUSY is abandoned and never committed.
  - Memory array contents are not reset (retain previous values, X after power-up).
- Reads of never-written words return whatever the array holds; benches write before reading.

Test Plan:
1. LATENCY=2, BASE=0.
   - Store 0xDEADBEEF to 0x10, strb 4'b1111.
   - Then load 0x10 with resp_ready=1.
   - Required: each resp_valid rises exactly 2 cycles after its accept edge. Store response has rdata 0, err 0. Load response has rdata 0xDEADBEEF, err 0.
2. After scenario 1, store 0x000000AA to 0x10 with strb 4'b0001, then load 0x10 -> rdata 0xDEADBEAA.
3. Load 0x12 (misaligned) -> resp_err 1, rdata 0. A subsequent load of 0x10 still returns 0xDEADBEAA.
4. DEPTH_WORDS=1024, store to 0x1000 (first out-of-range address) -> err 1. Load of 0x0FFC succeeds with err 0; it returns the value written earlier to 0x0FFC.
5. Backpressure:
   - Hold resp_ready=0 for 5 cycles in RESP while driving req_valid=1 with a new request.
   - Required: resp_valid, rdata and err stay stable; req_ready stays 0; the new request is not accepted until the cycle after the response handshake.
6. Reset mid-transaction:
   - Store 0x12345678 to 0x10 and pulse reset low during BUSY.
   - Required: outputs go to 0 immediately. A later load of 0x10 returns 0xDEADBEAA, so the store was not committed.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Data-bus request/response channel between the core (master) and a memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_strb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_strb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: fixed-latency load/store against an internal word array,
// returning read data and an error flag for misaligned or out-of-range accesses.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input logic               clk,
  input logic               reset,
  dmem_responder_if.slave   bus
);

  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W      = $clog2(LATENCY + 1);
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q;
  logic               we_q;
  logic [31:0]        wdata_q;
  logic [3:0]         strb_q;
  logic [31:0]        rdata_q;
  logic               err_q;
  logic               resp_valid_q;

  logic               req_ready_c;
  logic               accept_c;
  logic               access_c;
  logic               err_c;
  logic [31:0]        offset_c;
  logic [IDX_W-1:0]   index_c;

  logic [31:0]        mem [DEPTH_WORDS];

  assign req_ready_c = (state_q == IDLE) && reset;
  assign accept_c    = req_ready_c && bus.req_valid;
  assign access_c    = (state_q == BUSY) && (cnt_q == '0);

  // Address decode on the latched request; offset wraps so addresses below BASE_ADDR fall out of range.
  assign offset_c = addr_q - BASE_ADDR;
  assign err_c    = (addr_q[1:0] != 2'b00) || ({1'b0, offset_c} >= SPAN_BYTES);
  assign index_c  = offset_c[IDX_W+1:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= (state_d == RESP);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Request capture and response registers; response fields only change at the access edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept_c) begin
        addr_q  <= bus.req_addr;
        we_q    <= bus.req_we;
        wdata_q <= bus.req_wdata;
        strb_q  <= bus.req_strb;
      end
      if (access_c) begin
        rdata_q <= (!we_q && !err_c) ? mem[index_c] : 32'h0;
        err_q   <= err_c;
      end
    end
  end

  // Array has no reset; a store abandoned by reset never reaches access_c.
  always_ff @(posedge clk) begin
    if (access_c && we_q && !err_c) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) begin
          mem[index_c][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests push expected responses, a monitor checks them.
module tb_dmem_responder;

  localparam int unsigned LAT = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic clk;
  logic reset;
  int   cycle;
  int   n_checks;
  int   n_fail;
  int   hs_cycle;
  int   hold;
  logic prev_valid;
  logic [31:0] held_rdata;
  logic        held_err;
  exp_t sb[$];

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_WORDS (1024),
    .LATENCY     (LAT),
    .BASE_ADDR   (32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // resp_ready controller: drop ready for `hold` cycles of an offered response.
  always @(posedge clk) begin
    #2;
    if (bus.resp_valid && hold > 0) begin
      bus.resp_ready = 1'b0;
      hold--;
    end else begin
      bus.resp_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each new response, then checks it stays stable until taken.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.resp_valid) begin
        chk("req_ready_low_in_resp", 32'(bus.req_ready), 32'h0);
        if (!prev_valid) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_response: got rdata 0x%08h err %0b with empty scoreboard",
                     bus.resp_rdata, bus.resp_err);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("resp_rdata", bus.resp_rdata, e.rdata);
            chk("resp_err", 32'(bus.resp_err), 32'(e.err));
            chk("resp_latency", 32'(cycle - e.acc), 32'(LAT));
          end
          held_rdata = bus.resp_rdata;
          held_err   = bus.resp_err;
        end else begin
          chk("hold_rdata", bus.resp_rdata, held_rdata);
          chk("hold_err", 32'(bus.resp_err), 32'(held_err));
        end
        if (bus.resp_ready) hs_cycle = cycle + 1;
      end
      prev_valid = bus.resp_valid && !bus.resp_ready;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic issue(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [31:0] exp_rdata, input logic exp_err,
                       input bit push, input bit after_hs, output int acc);
    int guard;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_we    = we;
    bus.req_wdata = wdata;
    bus.req_strb  = strb;
    guard = 0;
    while (!bus.req_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL req_ready_timeout: addr 0x%08h never accepted", addr);
        bus.req_valid = 1'b0;
        acc = -1;
        return;
      end
    end
    acc = cycle + 1;
    if (push) sb.push_back('{rdata: exp_rdata, err: exp_err, acc: acc});
    if (after_hs) chk("accept_after_handshake", 32'(acc), 32'(hs_cycle + 1));
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || bus.resp_valid) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    int a0, a1;
    cycle = 0; n_checks = 0; n_fail = 0; hs_cycle = 0; hold = 0; prev_valid = 1'b0;
    reset = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_we = 1'b0;
    bus.req_wdata = '0; bus.req_strb = '0; bus.resp_ready = 1'b1;
    #1;
    chk("reset_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("reset_resp_rdata", bus.resp_rdata, 32'h0);
    chk("reset_resp_err", 32'(bus.resp_err), 32'h0);
    chk("reset_req_ready", 32'(bus.req_ready), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1 chk("post_reset_req_ready", 32'(bus.req_ready), 32'h1);

    // Full-word store then load
    issue(32'h10, 1'b1, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, 1, 0, a0);
    issue(32'h10, 1'b0, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0, 1, 0, a0);
    // Byte-lane store merges into existing word
    issue(32'h10, 1'b1, 32'h000000AA, 4'b0001, 32'h0, 1'b0, 1, 0, a0);
    issue(32'h10, 1'b0, 32'h0, 4'b0000, 32'hDEADBEAA, 1'b0, 1, 0, a0);
    // Empty-strobe store is a legal no-op
    issue(32'h10, 1'b1, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 1, 0, a0);
    // Misaligned load errors and leaves memory untouched
    issue(32'h12, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 1, 0, a0);
    issue(32'h10, 1'b0, 32'h0, 4'b0000, 32'hDEADBEAA, 1'b0, 1, 0, a0);
    // Range boundary: last word valid, first word past the array errors
    issue(32'h0FFC, 1'b1, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0, 1, 0, a0);
    issue(32'h1000, 1'b1, 32'h55555555, 4'b1111, 32'h0, 1'b1, 1, 0, a0);
    issue(32'h0FFC, 1'b0, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0, 1, 0, a0);
    issue(32'hFFFFFFFC, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 1, 0, a0);
    drain();

    // Backpressure: response held 5 cycles while the next request waits
    hold = 5;
    issue(32'h10, 1'b0, 32'h0, 4'b0000, 32'hDEADBEAA, 1'b0, 1, 0, a0);
    issue(32'h0FFC, 1'b0, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0, 1, 1, a1);
    chk("backpressure_handshake", 32'(hs_cycle), 32'(a0 + int'(LAT) + 6));
    drain();

    // Reset during BUSY abandons the store
    issue(32'h10, 1'b1, 32'h12345678, 4'b1111, 32'h0, 1'b0, 0, 0, a0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("midreset_resp_rdata", bus.resp_rdata, 32'h0);
    chk("midreset_resp_err", 32'(bus.resp_err), 32'h0);
    chk("midreset_req_ready", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("after_reset_no_resp", 32'(bus.resp_valid), 32'h0);
    issue(32'h10, 1'b0, 32'h0, 4'b0000, 32'hDEADBEAA, 1'b0, 1, 0, a0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
    $fatal(1, "watchdog expired");
  end

endmodule
